// File: rtl/clk_divider_pkg.sv
// Board-level constants shared by clock-generation logic.
//
// CLK_DIV_12MHZ_TO_1HZ : divide ratio that turns the 12 MHz board oscillator
//                        into a 1 Hz tick clock for counters and displays.
// CLK_DIV_WIDTH_DEF    : default counter width; comfortably holds the ratio above.
package clk_divider_pkg;

  localparam int unsigned CLK_DIV_12MHZ_TO_1HZ = 32'd12_000_000;
  localparam int unsigned CLK_DIV_WIDTH_DEF    = 32;

endpackage : clk_divider_pkg

// File: rtl/clk_divider.sv
// Integer clock divider: clkout = f(clk)/N with 50% duty for both even and odd N.
//
// Parameters
//   WIDTH : width of the cycle counter; N-1 must fit in WIDTH bits.
//   N     : division ratio, >= 1.
// Ports
//   clk    in   source clock (the only clock)
//   rst_n  in   synchronous active-low reset, sampled on clk edges
//   clkout out  divided clock; treat as its own clock domain downstream
//
// N == 1 bypasses clk straight through (reset has no effect). Even N uses the
// rising-edge phase register directly. Odd N ANDs it with a copy retimed on the
// falling edge, which trims half a clk period off the high time to get an
// exact N/2 high / N/2 low split.
module clk_divider
  import clk_divider_pkg::*;
#(
  parameter int unsigned WIDTH = CLK_DIV_WIDTH_DEF,
  parameter int unsigned N     = CLK_DIV_12MHZ_TO_1HZ
) (
  input  logic clk,
  input  logic rst_n,
  output logic clkout
);

  generate
    if (N == 0) begin : g_bad_n
      $error("clk_divider: N must be at least 1");
    end

    if (N > 0 && WIDTH < 64 && ((64'(N) - 64'd1) >> WIDTH) != 64'd0) begin : g_bad_width
      $error("clk_divider: N-1 does not fit in WIDTH bits");
    end

    if (N <= 1) begin : g_bypass
      // Reset is deliberately ignored on the bypass path.
      logic unused_rst_n;
      assign unused_rst_n = rst_n;
      assign clkout       = clk;
    end else begin : g_div
      localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(N - 1);
      localparam logic [WIDTH-1:0] CNT_HALF = WIDTH'(N / 2);

      logic [WIDTH-1:0] cnt_p;
      logic [WIDTH-1:0] cnt_p_nxt;
      logic             clk_p;

      always_comb begin
        cnt_p_nxt = cnt_p + WIDTH'(1);
        if (cnt_p == CNT_LAST) begin
          cnt_p_nxt = '0;
        end
      end

      // clk_p is decoded from the next count so it changes on the same edge
      // the counter crosses the half-way point: floor(N/2) low, ceil(N/2) high.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_p <= '0;
          clk_p <= 1'b0;
        end else begin
          cnt_p <= cnt_p_nxt;
          clk_p <= (cnt_p_nxt >= CNT_HALF);
        end
      end

      if ((N % 2) == 0) begin : g_even
        assign clkout = clk_p;
      end else begin : g_odd
        logic clk_n;

        // Half-period-delayed copy; the AND delays the rising edge of clkout
        // to the falling edge of clk while the falling edge stays put.
        always_ff @(negedge clk) begin
          if (!rst_n) begin
            clk_n <= 1'b0;
          end else begin
            clk_n <= clk_p;
          end
        end

        assign clkout = clk_p & clk_n;
      end
    end
  endgenerate

endmodule : clk_divider

// File: tb/tb_clk_divider.sv
// Scoreboard bench for clk_divider. Five instances (N = 1, 4, 5, 6, 12) share
// one clock and one reset. Every clk cycle the stimulus pushes the expected
// clkout of each instance for both clk phases; the monitor samples clkout 2
// time units after each clk edge and pops/compares.
module tb_clk_divider;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic c1, c4, c5, c6, c12;

  always #5 clk = ~clk;

  clk_divider #(.WIDTH(8), .N(1))  d1  (.clk(clk), .rst_n(rst_n), .clkout(c1));
  clk_divider #(.WIDTH(8), .N(4))  d4  (.clk(clk), .rst_n(rst_n), .clkout(c4));
  clk_divider #(.WIDTH(8), .N(5))  d5  (.clk(clk), .rst_n(rst_n), .clkout(c5));
  clk_divider #(.WIDTH(8), .N(6))  d6  (.clk(clk), .rst_n(rst_n), .clkout(c6));
  clk_divider #(.WIDTH(4), .N(12)) d12 (.clk(clk), .rst_n(rst_n), .clkout(c12));

  // Hand-derived clkout per half clk period, starting at the high phase of
  // the first rising edge after reset release (MSB first). Index h = 2*t+half,
  // t = active rising edges since release (0-based), half 0 = clk high phase.
  localparam bit [7:0]  P4  = 8'b0011_1100;
  localparam bit [9:0]  P5  = 10'b00011_11100;
  localparam bit [11:0] P6  = 12'b0000_1111_1100;
  localparam bit [23:0] P12 = 24'b0000000000_111111111111_00;

  typedef struct {
    logic [4:0] want;
    int         cyc;
  } item_t;

  item_t sb[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    n_of[5]     = '{1, 4, 5, 6, 12};
  int    t_cur       = -1;
  int    cyc         = 0;

  bit    count_en    = 1'b0;
  int    rises12     = 0;
  int    max_cnt12   = 0;

  function automatic logic [4:0] expect_at(input int t, input bit half);
    logic [4:0] v;
    int         h;
    v    = '0;
    v[0] = ~half;   // N=1 follows clk: high phase 1, low phase 0
    if (t >= 0) begin
      h    = 2 * t + int'(half);
      v[1] = P4[7 - (h % 8)];
      v[2] = P5[9 - (h % 10)];
      v[3] = P6[11 - (h % 12)];
      v[4] = P12[23 - (h % 24)];
    end
    return v;
  endfunction

  // One clk cycle: rst_n changes 1 unit before the rising edge, so both the
  // rising and the following falling edge see the same value.
  task automatic step(input logic r);
    item_t it;
    @(negedge clk);
    #4;
    rst_n = r;
    @(posedge clk);
    #1;
    t_cur   = r ? t_cur + 1 : -1;
    it.cyc  = cyc;
    it.want = expect_at(t_cur, 1'b0);
    sb.push_back(it);
    it.want = expect_at(t_cur, 1'b1);
    sb.push_back(it);
    cyc++;
  endtask

  task automatic check_sample(input bit half);
    item_t      it;
    logic [4:0] obs;
    obs = {c12, c6, c5, c4, c1};
    if (sb.size() == 0) return;
    it = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (obs[i] !== it.want[i]) begin
        miscompares++;
        $display("FAIL clkout_n%0d cyc=%0d half=%0d got=%b want=%b",
                 n_of[i], it.cyc, half, obs[i], it.want[i]);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      check_sample(1'b0);
      @(negedge clk);
      #2;
      check_sample(1'b1);
    end
  end

  always @(posedge c12) begin
    if (count_en) rises12++;
  end

  always @(negedge clk) begin
    if (count_en && int'(d12.g_div.cnt_p) > max_cnt12) begin
      max_cnt12 = int'(d12.g_div.cnt_p);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish, got time=%0t want earlier", $time);
    $fatal(1);
  end

  initial begin
    repeat (3)   step(1'b0);
    repeat (40)  step(1'b1);
    // Lands while N=6 is in its high phase (t=39 -> counter 4).
    step(1'b0);
    count_en = 1'b1;
    repeat (120) step(1'b1);
    count_en = 1'b0;
    repeat (3) @(posedge clk);
    #3;

    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got=%0d pending want=0", sb.size());
    end
    vectors++;
    if (rises12 != 10) begin
      miscompares++;
      $display("FAIL n12_rise_count got=%0d want=10", rises12);
    end
    vectors++;
    if (max_cnt12 != 11) begin
      miscompares++;
      $display("FAIL n12_max_cnt got=%0d want=11", max_cnt12);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_clk_divider
